// File: rtl/spi_pkg.sv
// Shared definitions for the DAC SPI link: receiver FSM states, frame
// geometry and the command codes understood by both writer and receiver.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DAC_FRAME_BITS = 24;
    localparam int DAC_DATA_BITS  = 16;

    localparam logic [7:0] CMD_WRITE_UPDATE = 8'h30;
    localparam logic [7:0] CMD_NOP          = 8'h00;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, followed by a
// rise/fall detector that compares the last stage with a delayed copy.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;

    // Shift the raw pin through the synchroniser chain and keep one extra
    // delayed copy of the settled level for edge detection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_last <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
            r_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level_o = r_sync[SYNC_STAGES-1];
    assign rise_o  = r_sync[SYNC_STAGES-1] & ~r_last;
    assign fall_o  = ~r_sync[SYNC_STAGES-1] & r_last;

endmodule

// File: rtl/dac_spi_receiver.sv
// Responder end of the DAC SPI link. Oversamples the SPI pins with the
// system clock, deserialises 24-bit frames into command and sample fields,
// and flags frames whose bit count is wrong.
module dac_spi_receiver
    import spi_pkg::*;
#(
    parameter int FRAME_BITS  = DAC_FRAME_BITS,
    parameter int DATA_BITS   = DAC_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 spi_clk_i,
    input  logic                 spi_mosi_i,
    input  logic                 spi_cs_i,
    input  logic                 dac_reset_ni,
    output logic [7:0]           cmd_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    // The counter must be able to hold FRAME_BITS+1 so overruns are visible.
    localparam int            CW       = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    logic w_sclkRise;
    logic w_unusedSclkLevel;
    logic w_unusedSclkFall;
    logic w_mosi;
    logic w_unusedMosiRise;
    logic w_unusedMosiFall;
    logic w_unusedCsLevel;
    logic w_csRise;
    logic w_csFall;
    logic w_dacRstN;
    logic w_unusedDacRise;
    logic w_unusedDacFall;

    state_t                r_state;
    state_t                w_nextState;
    logic [FRAME_BITS-1:0] r_sr;
    logic [CW-1:0]         r_count;
    logic [7:0]            r_cmd;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_frameErr;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncSclk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (spi_clk_i),
        .level_o (w_unusedSclkLevel),
        .rise_o  (w_sclkRise),
        .fall_o  (w_unusedSclkFall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncMosi (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (spi_mosi_i),
        .level_o (w_mosi),
        .rise_o  (w_unusedMosiRise),
        .fall_o  (w_unusedMosiFall)
    );

    // Chip select idles high, so its synchroniser resets high to avoid a
    // phantom falling edge straight out of reset.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncCs (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (spi_cs_i),
        .level_o (w_unusedCsLevel),
        .rise_o  (w_csRise),
        .fall_o  (w_csFall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncDacRst (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (dac_reset_ni),
        .level_o (w_dacRstN),
        .rise_o  (w_unusedDacRise),
        .fall_o  (w_unusedDacFall)
    );

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: frames open on a cs fall, close on a cs rise, and a held
    // DAC reset pins the FSM in IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_dacRstN && w_csFall) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_dacRstN || w_csRise) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: shift register, saturating bit counter, result registers
    // and the one-cycle result pulses. A cs rise takes priority over a
    // simultaneous sclk rise, so that last bit is dropped.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sr       <= '0;
            r_count    <= '0;
            r_cmd      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            if (!w_dacRstN) begin
                r_sr    <= '0;
                r_count <= '0;
                r_cmd   <= '0;
                r_data  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_csFall) begin
                            r_sr    <= '0;
                            r_count <= '0;
                        end
                    end
                    SHIFT: begin
                        if (w_csRise) begin
                            if (r_count == CNT_FULL) begin
                                r_cmd   <= r_sr[FRAME_BITS-1 -: 8];
                                r_data  <= r_sr[DATA_BITS-1:0];
                                r_valid <= 1'b1;
                            end else if (r_count != '0) begin
                                r_frameErr <= 1'b1;
                            end
                        end else if (w_sclkRise) begin
                            r_sr <= {r_sr[FRAME_BITS-2:0], w_mosi};
                            if (r_count != CNT_SAT) begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_o       = r_cmd;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frameErr;
    assign busy_o      = (r_state == SHIFT);

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Self-checking bench for dac_spi_receiver: a table of directed frames with
// hand-computed results, plus hand-written sequences for back-to-back
// frames, stray activity, system reset and DAC reset mid-frame.
module tb_dac_spi_receiver;

    localparam int HALF = 10;   // 2.5 MHz sclk from a 50 MHz clock

    logic        clk_i;
    logic        reset_i;
    logic        spi_clk_i;
    logic        spi_mosi_i;
    logic        spi_cs_i;
    logic        dac_reset_ni;
    logic [7:0]  cmd_o;
    logic [15:0] data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        busy_o;

    int testsRun    = 0;
    int testsFailed = 0;
    int validCount  = 0;
    int errCount    = 0;
    int bothHigh    = 0;
    int busySeen    = 0;
    logic [15:0] capData[$];

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          expValid;
        int          expErr;
        logic [7:0]  expCmd;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs[6];

    dac_spi_receiver dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .spi_clk_i    (spi_clk_i),
        .spi_mosi_i   (spi_mosi_i),
        .spi_cs_i     (spi_cs_i),
        .dac_reset_ni (dac_reset_ni),
        .cmd_o        (cmd_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #10 clk_i = ~clk_i;

    // Pulse monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk_i) begin
        if (valid_o) begin
            validCount++;
            capData.push_back(data_o);
        end
        if (frame_err_o) errCount++;
        if (valid_o && frame_err_o) bothHigh++;
        if (busy_o) busySeen = 1;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Clocks out the low nbits of word, MSB first, with cs already low.
    task automatic sendBits(input logic [31:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi_i = word[i];
            waitCycles(HALF);
            spi_clk_i = 1'b1;
            waitCycles(HALF);
            spi_clk_i = 1'b0;
        end
    endtask

    // One complete select: cs low, bits, cs high, then a gap with cs high.
    task automatic applyStimulus(input logic [31:0] word, input int nbits, input int gap);
        spi_cs_i = 1'b0;
        waitCycles(4);
        sendBits(word, nbits);
        waitCycles(4);
        spi_cs_i = 1'b1;
        waitCycles(gap);
    endtask

    initial begin
        int v0;
        int e0;
        reset_i      = 1'b1;
        spi_clk_i    = 1'b0;
        spi_mosi_i   = 1'b0;
        spi_cs_i     = 1'b1;
        dac_reset_ni = 1'b1;

        vecs[0] = '{32'h0030_7FFF, 24, 1, 0, 8'h30, 16'h7FFF};
        vecs[1] = '{32'h00A5_1234, 24, 1, 0, 8'hA5, 16'h1234};
        vecs[2] = '{32'h0012_3456, 23, 0, 1, 8'hA5, 16'h1234};
        vecs[3] = '{32'h01AB_CDEF, 25, 0, 1, 8'hA5, 16'h1234};
        vecs[4] = '{32'h0000_0000,  0, 0, 0, 8'hA5, 16'h1234};
        vecs[5] = '{32'h0030_C3A5, 24, 1, 0, 8'h30, 16'hC3A5};

        waitCycles(5);
        checkOutput("reset_cmd",   int'(cmd_o), 0);
        checkOutput("reset_data",  int'(data_o), 0);
        checkOutput("reset_valid", int'(valid_o), 0);
        checkOutput("reset_err",   int'(frame_err_o), 0);
        checkOutput("reset_busy",  int'(busy_o), 0);
        reset_i = 1'b0;
        waitCycles(5);

        // Directed frame table.
        for (int k = 0; k < 6; k++) begin
            v0 = validCount;
            e0 = errCount;
            applyStimulus(vecs[k].word, vecs[k].nbits, 8);
            checkOutput($sformatf("vec%0d_valid", k), validCount - v0, vecs[k].expValid);
            checkOutput($sformatf("vec%0d_err", k),   errCount - e0,   vecs[k].expErr);
            checkOutput($sformatf("vec%0d_cmd", k),   int'(cmd_o),     int'(vecs[k].expCmd));
            checkOutput($sformatf("vec%0d_data", k),  int'(data_o),    int'(vecs[k].expData));
            checkOutput($sformatf("vec%0d_busy", k),  int'(busy_o),    0);
        end

        // Back-to-back signed samples with a minimum two-cycle cs gap.
        v0 = validCount;
        e0 = errCount;
        applyStimulus(32'h0030_8000, 24, 2);
        applyStimulus(32'h0030_FFFF, 24, 8);
        checkOutput("b2b_valid", validCount - v0, 2);
        checkOutput("b2b_err",   errCount - e0,   0);
        checkOutput("b2b_first",  int'($signed(capData[capData.size()-2])), -32768);
        checkOutput("b2b_second", int'($signed(capData[capData.size()-1])), -1);
        checkOutput("b2b_data_signed", int'($signed(data_o)), -1);

        // Stray sclk with cs high: no pulses and busy never asserted.
        v0 = validCount;
        e0 = errCount;
        busySeen = 0;
        sendBits(32'h0000_00FF, 8);
        waitCycles(8);
        checkOutput("stray_valid", validCount - v0, 0);
        checkOutput("stray_err",   errCount - e0,   0);
        checkOutput("stray_busy",  busySeen,        0);

        // System reset after 12 bits, then a clean frame.
        v0 = validCount;
        e0 = errCount;
        spi_cs_i = 1'b0;
        waitCycles(4);
        sendBits(32'h0000_0ABC, 12);
        reset_i = 1'b1;
        waitCycles(3);
        spi_cs_i = 1'b1;
        waitCycles(3);
        reset_i = 1'b0;
        waitCycles(8);
        checkOutput("rst_abort_valid", validCount - v0, 0);
        checkOutput("rst_abort_err",   errCount - e0,   0);
        checkOutput("rst_abort_busy",  int'(busy_o),    0);
        applyStimulus(32'h0030_1234, 24, 8);
        checkOutput("rst_resume_valid", validCount - v0, 1);
        checkOutput("rst_resume_data",  int'(data_o), 16'h1234);

        // DAC reset after a good frame clears the outputs.
        applyStimulus(32'h0030_4321, 24, 8);
        checkOutput("dac_pre_data", int'(data_o), 16'h4321);
        checkOutput("dac_pre_cmd",  int'(cmd_o),  8'h30);
        v0 = validCount;
        e0 = errCount;
        dac_reset_ni = 1'b0;
        waitCycles(5);
        dac_reset_ni = 1'b1;
        waitCycles(4);
        checkOutput("dac_clear_data", int'(data_o), 0);
        checkOutput("dac_clear_cmd",  int'(cmd_o),  0);

        // DAC reset mid-frame aborts it; remaining bits and the cs rise
        // arrive while idle and produce nothing.
        spi_cs_i = 1'b0;
        waitCycles(4);
        sendBits(32'h0000_0155, 10);
        dac_reset_ni = 1'b0;
        waitCycles(5);
        dac_reset_ni = 1'b1;
        waitCycles(4);
        checkOutput("dac_mid_busy", int'(busy_o), 0);
        sendBits(32'h0000_2AAA, 14);
        waitCycles(4);
        spi_cs_i = 1'b1;
        waitCycles(8);
        checkOutput("dac_mid_valid", validCount - v0, 0);
        checkOutput("dac_mid_err",   errCount - e0,   0);
        checkOutput("dac_mid_data",  int'(data_o),    0);

        checkOutput("no_valid_err_overlap", bothHigh, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
